// File: rtl/inst_mem_loader_pkg.sv
// Shared types and constants for the instruction memory loader.
// Default widths come from INST_LENGTH / INSTMEM_ADDR_WIDTH when the build does not define them.
`ifndef INST_LENGTH
`define INST_LENGTH 16
`endif
`ifndef INSTMEM_ADDR_WIDTH
`define INSTMEM_ADDR_WIDTH 8
`endif

package inst_mem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN0,
        LEN1,
        DATA,
        WRITE,
        CSUM,
        DONE,
        ERR
    } state_t;

    localparam int HDR_BYTES  = 2;
    localparam int DEF_INST_W = `INST_LENGTH;
    localparam int DEF_ADDR_W = `INSTMEM_ADDR_WIDTH;

    function automatic int bytes_per_inst(input int inst_w);
        return (inst_w + 7) / 8;
    endfunction

endpackage

// File: rtl/inst_byte_packer.sv
// Little-endian byte-to-instruction assembler: byte k of an instruction lands in bits [8k+7:8k].
// word_nxt already includes the byte being loaded so the caller can capture a finished word in one cycle.
module inst_byte_packer
    import inst_mem_loader_pkg::*;
#(
    parameter int INST_W = DEF_INST_W
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              load,
    input  logic [7:0]        byte_in,
    output logic [INST_W-1:0] word_nxt,
    output logic              last
);

    localparam int BPI   = bytes_per_inst(INST_W);
    localparam int CNT_W = (BPI > 1) ? $clog2(BPI) : 1;

    logic [CNT_W-1:0] byte_cnt;
    logic [8*BPI-1:0] asm_q;
    logic [8*BPI-1:0] asm_nxt;

    assign last = (byte_cnt == CNT_W'(BPI - 1));

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        asm_nxt = asm_q;
        if (load) begin
            asm_nxt[8*byte_cnt +: 8] = byte_in;
        end
    end

    // Padding bits above INST_W are simply never forwarded.
    assign word_nxt = asm_nxt[INST_W-1:0];

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            byte_cnt <= '0;
            asm_q    <= '0;
        end else if (clear) begin
            byte_cnt <= '0;
            asm_q    <= '0;
        end else if (load) begin
            asm_q    <= asm_nxt;
            byte_cnt <= last ? '0 : byte_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/inst_mem_loader.sv
// Host byte stream -> instruction memory write port, holding the core in reset until the program is in.
// Optional trailing XOR checksum byte is enabled with INSTLOAD_CHECKSUM_EN.
module inst_mem_loader
    import inst_mem_loader_pkg::*;
#(
    parameter int INST_W = DEF_INST_W,
    parameter int ADDR_W = DEF_ADDR_W
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [INST_W-1:0] wr_data,
    output logic              core_hold,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   loaded_count
);

    // Largest legal program: exactly fills the memory, so the address never wraps.
    localparam logic [16:0] MAX_LEN = 17'(1) << ADDR_W;

    state_t            state;
    state_t            state_nxt;
    logic [15:0]       len;
    logic [15:0]       len_in;
    logic [ADDR_W-1:0] addr_cnt;
    logic [ADDR_W:0]   count_inc;
    logic              xfer;
    logic              start_ok;
    logic              pk_clear;
    logic              pk_last;
    logic [INST_W-1:0] pk_word;
`ifdef INSTLOAD_CHECKSUM_EN
    logic [7:0]        csum;
`endif

    assign in_ready  = (state inside {LEN0, LEN1, DATA, CSUM});
    assign wr_en     = (state == WRITE);
    assign done      = (state == DONE);
    assign err       = (state == ERR);
    assign core_hold = (state != DONE);

    assign xfer      = in_valid && in_ready;
    assign start_ok  = start && (state inside {IDLE, DONE, ERR});
    assign len_in    = {in_data, len[7:0]};
    assign count_inc = loaded_count + 1'b1;
    assign pk_clear  = start_ok || (xfer && (state == LEN1));

    inst_byte_packer #(
        .INST_W (INST_W)
    ) u_packer (
        .clk      (clk),
        .reset    (reset),
        .clear    (pk_clear),
        .load     (xfer && (state == DATA)),
        .byte_in  (in_data),
        .word_nxt (pk_word),
        .last     (pk_last)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start) state_nxt = LEN0;
            LEN0:  if (xfer) state_nxt = LEN1;
            LEN1: begin
                if (xfer) begin
                    if ({1'b0, len_in} > MAX_LEN) begin
                        state_nxt = ERR;
                    end else if (len_in == 16'd0) begin
`ifdef INSTLOAD_CHECKSUM_EN
                        state_nxt = CSUM;
`else
                        state_nxt = DONE;
`endif
                    end else begin
                        state_nxt = DATA;
                    end
                end
            end
            DATA:  if (xfer && pk_last) state_nxt = WRITE;
            WRITE: begin
                if (17'(count_inc) == {1'b0, len}) begin
`ifdef INSTLOAD_CHECKSUM_EN
                    state_nxt = CSUM;
`else
                    state_nxt = DONE;
`endif
                end else begin
                    state_nxt = DATA;
                end
            end
`ifdef INSTLOAD_CHECKSUM_EN
            CSUM:  if (xfer) state_nxt = (in_data == csum) ? DONE : ERR;
`endif
            DONE:  if (start) state_nxt = LEN0;
            ERR:   if (start) state_nxt = LEN0;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            len          <= '0;
            addr_cnt     <= '0;
            loaded_count <= '0;
            wr_addr      <= '0;
            wr_data      <= '0;
`ifdef INSTLOAD_CHECKSUM_EN
            csum         <= '0;
`endif
        end else begin
            state <= state_nxt;
            if (start_ok) begin
                loaded_count <= '0;
                addr_cnt     <= '0;
`ifdef INSTLOAD_CHECKSUM_EN
                csum         <= '0;
`endif
            end
            if (xfer && (state == LEN0)) len[7:0] <= in_data;
            if (xfer && (state == LEN1)) begin
                len[15:8] <= in_data;
                addr_cnt  <= '0;
            end
            // Capture the finished word as the last byte arrives; holds until the next write.
            if (xfer && (state == DATA) && pk_last) begin
                wr_addr <= addr_cnt;
                wr_data <= pk_word;
            end
            if (state == WRITE) begin
                addr_cnt     <= addr_cnt + 1'b1;
                loaded_count <= count_inc;
            end
`ifdef INSTLOAD_CHECKSUM_EN
            if (xfer && (state inside {LEN0, LEN1, DATA})) csum <= csum ^ in_data;
`endif
        end
    end

endmodule

// File: tb/tb_inst_mem_loader.sv
// Directed bench for inst_mem_loader: normal load, gapped stream, length limits, reset mid-load, restart.
// Adds the trailing checksum byte and checksum cases when built with INSTLOAD_CHECKSUM_EN.
module tb_inst_mem_loader;

`ifdef INSTLOAD_CHECKSUM_EN
    localparam bit CSUM_ON = 1'b1;
`else
    localparam bit CSUM_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [15:0] wr_data;
    logic        core_hold;
    logic        done;
    logic        err;
    logic [8:0]  loaded_count;

    inst_mem_loader dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .core_hold    (core_hold),
        .done         (done),
        .err          (err),
        .loaded_count (loaded_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int wa[$];
    int wd[$];
    int wc[$];
    int rdy_in_write = 0;
    logic [7:0] stim[$];
    int gap = 0;

    always @(posedge clk) cyc++;

    // Write-port monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (wr_en) begin
            wa.push_back(int'(wr_addr));
            wd.push_back(int'(wr_data));
            wc.push_back(cyc);
            if (in_ready) rdy_in_write++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        wa.delete();
        wd.delete();
        wc.delete();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called on a falling edge; returns on the falling edge after the byte was taken.
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("ready_timeout", 32'(n), 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic run_stim(input bit with_csum);
        logic [7:0] sum = 8'h00;
        foreach (stim[i]) begin
            send_byte(stim[i]);
            sum ^= stim[i];
            if (gap != 0) @(negedge clk);
        end
        if (with_csum && CSUM_ON) send_byte(sum);
    endtask

    task automatic wait_end();
        int n = 0;
        while (!done && !err && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("end_reached", 32'(done | err), 32'd1);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check("rst_core_hold", 32'(core_hold), 32'd1);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_count", 32'(loaded_count), 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Two instructions, in_valid held high
        clear_log();
        pulse_start();
        stim = '{8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56};
        gap = 0;
        run_stim(1'b1);
        wait_end();
        check("t1_nwrites", 32'(wa.size()), 32'd2);
        if (wa.size() == 2) begin
            check("t1_addr0", 32'(wa[0]), 32'd0);
            check("t1_data0", 32'(wd[0]), 32'h1234);
            check("t1_addr1", 32'(wa[1]), 32'd1);
            check("t1_data1", 32'(wd[1]), 32'h5678);
            check("t1_spacing", 32'(wc[1] - wc[0]), 32'd3);
        end
        check("t1_done", 32'(done), 32'd1);
        check("t1_core_hold", 32'(core_hold), 32'd0);
        check("t1_count", 32'(loaded_count), 32'd2);
        check("t1_hold_addr", 32'(wr_addr), 32'd1);
        check("t1_hold_data", 32'(wr_data), 32'h5678);

        // Same stream with gaps between bytes
        clear_log();
        rdy_in_write = 0;
        pulse_start();
        gap = 1;
        run_stim(1'b1);
        wait_end();
        gap = 0;
        check("t2_nwrites", 32'(wa.size()), 32'd2);
        if (wa.size() == 2) begin
            check("t2_addr0", 32'(wa[0]), 32'd0);
            check("t2_data0", 32'(wd[0]), 32'h1234);
            check("t2_addr1", 32'(wa[1]), 32'd1);
            check("t2_data1", 32'(wd[1]), 32'h5678);
        end
        check("t2_ready_in_write", 32'(rdy_in_write), 32'd0);
        check("t2_done", 32'(done), 32'd1);

        // len = 0
        clear_log();
        pulse_start();
        stim = '{8'h00, 8'h00};
        run_stim(1'b1);
        wait_end();
        check("t3_nwrites", 32'(wa.size()), 32'd0);
        check("t3_done", 32'(done), 32'd1);
        check("t3_count", 32'(loaded_count), 32'd0);

        // len = 256, fills the memory
        clear_log();
        pulse_start();
        stim = '{8'h00, 8'h01};
        for (int i = 0; i < 256; i++) begin
            stim.push_back(8'(i));
            stim.push_back(8'(i) ^ 8'hA5);
        end
        run_stim(1'b1);
        wait_end();
        check("t4_nwrites", 32'(wa.size()), 32'd256);
        if (wa.size() == 256) begin
            check("t4_first_data", 32'(wd[0]), 32'hA500);
            check("t4_last_addr", 32'(wa[255]), 32'hFF);
            check("t4_last_data", 32'(wd[255]), 32'h5AFF);
        end
        check("t4_done", 32'(done), 32'd1);
        check("t4_count", 32'(loaded_count), 32'd256);

        // len = 257 is rejected
        clear_log();
        pulse_start();
        stim = '{8'h01, 8'h01};
        run_stim(1'b0);
        wait_end();
        check("t5_err", 32'(err), 32'd1);
        check("t5_done", 32'(done), 32'd0);
        check("t5_core_hold", 32'(core_hold), 32'd1);
        check("t5_nwrites", 32'(wa.size()), 32'd0);

        // Reset after the first instruction byte
        clear_log();
        pulse_start();
        stim = '{8'h01, 8'h00, 8'h34};
        run_stim(1'b0);
        reset = 1'b0;
        #1;
        check("t6_core_hold", 32'(core_hold), 32'd1);
        check("t6_in_ready", 32'(in_ready), 32'd0);
        check("t6_wr_en", 32'(wr_en), 32'd0);
        check("t6_done", 32'(done), 32'd0);
        check("t6_err", 32'(err), 32'd0);
        check("t6_count", 32'(loaded_count), 32'd0);
        check("t6_wr_addr", 32'(wr_addr), 32'd0);
        check("t6_wr_data", 32'(wr_data), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("t6_idle_ready", 32'(in_ready), 32'd0);
        clear_log();
        pulse_start();
        stim = '{8'h01, 8'h00, 8'hEF, 8'hBE};
        run_stim(1'b1);
        wait_end();
        check("t6_nwrites", 32'(wa.size()), 32'd1);
        if (wa.size() == 1) begin
            check("t6_addr", 32'(wa[0]), 32'd0);
            check("t6_data", 32'(wd[0]), 32'hBEEF);
        end
        check("t6_reload_done", 32'(done), 32'd1);

        // Restart from DONE
        clear_log();
        pulse_start();
        check("t7_core_hold", 32'(core_hold), 32'd1);
        check("t7_done", 32'(done), 32'd0);
        check("t7_count_clr", 32'(loaded_count), 32'd0);
        stim = '{8'h01, 8'h00, 8'hCD, 8'hAB};
        run_stim(1'b1);
        wait_end();
        check("t7_nwrites", 32'(wa.size()), 32'd1);
        if (wa.size() == 1) begin
            check("t7_addr", 32'(wa[0]), 32'd0);
            check("t7_data", 32'(wd[0]), 32'hABCD);
        end
        check("t7_count", 32'(loaded_count), 32'd1);
        check("t7_release", 32'(core_hold), 32'd0);

`ifdef INSTLOAD_CHECKSUM_EN
        // Explicit checksum bytes
        pulse_start();
        stim = '{8'h01, 8'h00, 8'h34, 8'h12, 8'h27};
        run_stim(1'b0);
        wait_end();
        check("t8_good_done", 32'(done), 32'd1);
        check("t8_good_err", 32'(err), 32'd0);
        pulse_start();
        stim = '{8'h01, 8'h00, 8'h34, 8'h12, 8'h00};
        run_stim(1'b0);
        wait_end();
        check("t8_bad_err", 32'(err), 32'd1);
        check("t8_bad_hold", 32'(core_hold), 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_mem_loader.md
Name: inst_mem_loader

Overview:
- Write-side counterpart to the instruction fetch path: the scheduler only reads instruction memory (inst_addr -> inst); this block fills it.
- Accepts a byte stream from the host/debug port with a valid/ready handshake, assembles instructions, and issues one-cycle writes to the instruction memory write port.
- Holds the SM core (scheduler PC) in reset via core_hold until a complete program is loaded.

Parameters:
- INST_W, `INST_LENGTH (16), instruction width in bits.
- ADDR_W, `INSTMEM_ADDR_WIDTH (8), instruction memory address width.
- BPI, (INST_W+7)/8 (2), bytes per instruction, derived; not overridden.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low.
- start  input  1  one-cycle pulse; begins a load from IDLE, DONE or ERR; ignored in other states.
- in_valid  input  1  host byte valid.
- in_data  input  8  host byte.
- in_ready  output  1  loader accepts in_data this cycle.
- wr_en  output  1  instruction memory write strobe.
- wr_addr  output  ADDR_W  write address.
- wr_data  output  INST_W  write data.
- core_hold  output  1  1 = keep scheduler/PC in reset.
- done  output  1  program loaded, core released.
- err  output  1  load aborted.
- loaded_count  output  ADDR_W+1  instructions written in current/last load.

Behaviour:
- Reset (async, reset=0): state IDLE; in_ready=0, wr_en=0, wr_addr=0, wr_data=0, core_hold=1, done=0, err=0, loaded_count=0; length, byte and address counters cleared.
- A byte transfers only on a cycle with in_valid=1 and in_ready=1. in_ready is registered-state decoded: 1 in LEN0, LEN1 and DATA; 0 in all other states.
- States and transitions:
  - IDLE: wait for start -> LEN0.
  - LEN0: on transfer, len[7:0] <= byte -> LEN1.
  - LEN1: on transfer, len[15:8] <= byte.
    - len==0 -> DONE.
    - len > 2^ADDR_W -> ERR.
    - otherwise clear addr/byte counters -> DATA.
  - DATA: each transfer places the byte little-endian into the assembly register (byte k -> bits [8k+7:8k]); bits above INST_W are dropped. On the BPI-th byte -> WRITE.
  - WRITE: wr_en=1 for exactly this cycle, with wr_addr=addr_cnt and wr_data=assembled word. Then addr_cnt++ and loaded_count++.
    - loaded_count==len -> DONE.
    - otherwise -> DATA.
  - DONE: done=1, core_hold=0; holds until start.
  - ERR: err=1, core_hold=1; holds until start.
- start from DONE or ERR: clear done, err and loaded_count; set core_hold=1 the next cycle; -> LEN0.
- Throughput: with in_valid held high, one instruction costs BPI+1 cycles. wr_en rises the cycle after the last byte is accepted.
- Address wrap is impossible: len is capped at 2^ADDR_W. A final write at address 2^ADDR_W-1 is legal.
- wr_addr and wr_data hold their last values when wr_en=0.
- Reset mid-load aborts immediately. Memory already written is not cleared. Outputs return to reset values.

Optional Feature:
- INSTLOAD_CHECKSUM_EN:
  - Defined: after the last WRITE, the FSM enters CSUM (in_ready=1) and takes one byte. It must equal the XOR of all data bytes and both length bytes.
    - Match -> DONE.
    - Mismatch -> ERR, core_hold stays 1.
    - For len==0 the checksum covers the length bytes only.
  - Undefined: no CSUM state; the transitions above apply unchanged.

Decomposition:
- Shared package: state enum (IDLE, LEN0, LEN1, DATA, WRITE, CSUM, DONE, ERR), header byte count constant, derived BPI.
- Natural sub-module: inst_byte_packer (byte counter plus little-endian assembly register; load/clear inputs, word and last-byte outputs).
- The FSM stays in inst_mem_loader.

Test Plan:
- Reset: reset=0 -> core_hold=1, in_ready=0, wr_en=0, done=0. start then bytes 02 00 | 34 12 | 78 56 with in_valid always 1 -> writes (addr 0, 0x1234), (addr 1, 0x5678). Each wr_en lasts 1 cycle, 3 cycles apart. done=1, core_hold=0, loaded_count=2.
- Backpressure/gaps: same stream with in_valid toggling every other cycle -> identical writes and no duplicate bytes. in_ready=0 during WRITE.
- Length boundaries:
  - len=0 (00 00) -> DONE directly, no wr_en.
  - len=256 -> last write at addr 0xFF.
  - len=257 (01 01) -> ERR, core_hold=1, no wr_en.
- Reset mid-load: assert reset=0 after the first instruction byte -> all outputs at reset values. A following start reloads cleanly from addr 0.
- Restart: start in DONE -> core_hold=1 next cycle, done=0. New 1-instruction load writes addr 0.
- INSTLOAD_CHECKSUM_EN:
  - 01 00 34 12, checksum 0x27 -> DONE.
  - Checksum 0x00 -> ERR.
